// File: rtl/icache_pkg.sv
// Shared geometry, FSM encodings and address field helpers for the instruction cache.
package icache_pkg;
   localparam int LINES       = 8;
   localparam int BLOCK_WORDS = 4;
   localparam int ADDR_W      = 32;
   localparam int INDEX_W     = $clog2(LINES);
   localparam int OFFS_W      = $clog2(BLOCK_WORDS);
   localparam int TAG_W       = ADDR_W - 2 - OFFS_W - INDEX_W;
   localparam int BLK_W       = TAG_W + INDEX_W;
   localparam int LINE_W      = 32 * BLOCK_WORDS;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MEM_READ = 2'd1;
   localparam logic [1:0] UPDATE   = 2'd2;

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
      return a[2+OFFS_W +: INDEX_W];
   endfunction

   function automatic logic [OFFS_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
      return a[2 +: OFFS_W];
   endfunction
endpackage

// File: rtl/icache_line_array.sv
// Data/tag/valid storage: async read of one line, sync write of one line, async clear of valid bits.
module icache_line_array
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [INDEX_W-1:0] rd_index,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_data
);
   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags [LINES];
   logic [LINE_W-1:0] data [LINES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         valid <= '0;
      else if (wr_en)
         valid[wr_index] <= 1'b1;
   end

   // Tag and data contents are meaningless until valid is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[rd_index];
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, 3-state refill FSM.
module instruction_cache
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   output logic [31:0]       instruction,
   output logic              busywait,
   output logic              mem_read,
   output logic [BLK_W-1:0]  mem_address,
   input  logic [LINE_W-1:0] mem_readdata,
   input  logic              mem_busywait
);
   logic [1:0]         state;
   logic [BLK_W-1:0]   miss_addr;
   logic [LINE_W-1:0]  line_buf;
   logic [TAG_W-1:0]   tag;
   logic [INDEX_W-1:0] index;
   logic [OFFS_W-1:0]  offset;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [LINE_W-1:0]  rd_data;
   logic               hit;
   logic               unused_byte_bits;

   assign tag              = get_tag(address);
   assign index            = get_index(address);
   assign offset           = get_offset(address);
   assign unused_byte_bits = ^address[1:0];

   icache_line_array u_lines (
      .clk      (clk),
      .reset    (reset),
      .rd_index (index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (state == UPDATE),
      .wr_index (miss_addr[INDEX_W-1:0]),
      .wr_tag   (miss_addr[BLK_W-1:INDEX_W]),
      .wr_data  (line_buf)
   );

   // Hits only count in IDLE so the CPU never sees a line while it is being replaced.
   assign hit         = rd_valid && (rd_tag == tag) && (state == IDLE);
   assign instruction = hit ? rd_data[{offset, 5'b0} +: 32] : 32'h0;
   assign busywait    = reset && !hit;
   assign mem_read    = (state == MEM_READ);
   assign mem_address = miss_addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         miss_addr <= '0;
      end else begin
         case (state)
            IDLE: if (!hit) begin
               miss_addr <= {tag, index};
               state     <= MEM_READ;
            end
            MEM_READ: if (!mem_busywait) state <= UPDATE;
            UPDATE:   state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == MEM_READ && !mem_busywait)
         line_buf <= mem_readdata;
   end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural instruction memory.
module tb_instruction_cache;
   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  address;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;
   logic         zero_mode;
   int           mem_cnt;
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   instruction_cache dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   // Memory: busy for the first 4 request cycles, data on the 5th; word at A is A ^ A5A5_0000.
   always @(posedge clk) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
   assign mem_busywait = mem_read && !zero_mode && (mem_cnt < 4);
   always_comb begin
      mem_readdata = '0;
      for (int i = 0; i < 4; i++)
         mem_readdata[i*32 +: 32] = ({mem_address, 4'b0} + 32'(i*4)) ^ 32'hA5A5_0000;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_addr(input logic [31:0] a);
      @(posedge clk);
      #1 address = a;
   endtask

   // Counts stall cycles until a hit, plus refill requests issued along the way.
   task automatic measure(input string tag, input int exp_stalls, input logic [31:0] exp_instr,
                          input int exp_reqs, input logic [31:0] exp_last);
      int stalls = 0;
      int reqs = 0;
      logic [31:0] last = '0;
      logic prev = mem_read;
      bit timed_out = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_read && !prev) begin
            reqs++;
            last = {4'b0, mem_address};
         end
         prev = mem_read;
         if (!busywait) begin
            timed_out = 1'b0;
            break;
         end
         stalls++;
      end
      check({tag, "_timeout"}, 32'(timed_out), 32'd0);
      check({tag, "_stalls"}, stalls, exp_stalls);
      check({tag, "_instr"}, instruction, exp_instr);
      check({tag, "_reqs"}, reqs, exp_reqs);
      check({tag, "_memaddr"}, last, exp_last);
   endtask

   initial begin
      reset     = 1'b0;
      address   = 32'h0;
      zero_mode = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busywait", 32'(busywait), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_addr", {4'b0, mem_address}, 32'd0);
      check("rst_instr", instruction, 32'h0);

      // 1: cold miss on 0x00
      @(posedge clk);
      #1 reset = 1'b1;
      measure("t1", 7, 32'hA5A5_0000, 1, 32'h0);

      // 2: same line hits
      set_addr(32'h04); measure("t2a", 0, 32'hA5A5_0004, 0, 32'h0);
      set_addr(32'h08); measure("t2b", 0, 32'hA5A5_0008, 0, 32'h0);
      set_addr(32'h0C); measure("t2c", 0, 32'hA5A5_000C, 0, 32'h0);

      // 3: conflict on index 0
      set_addr(32'h80); measure("t3a", 7, 32'hA5A5_0080, 1, 32'h8);
      set_addr(32'h00); measure("t3b", 7, 32'hA5A5_0000, 1, 32'h0);

      // 4: address moves to 0x40 while block 0x10 is being fetched
      set_addr(32'h10);
      repeat (3) @(negedge clk);
      check("t4_mem_read", 32'(mem_read), 32'd1);
      check("t4_mem_addr", {4'b0, mem_address}, 32'h1);
      set_addr(32'h40); measure("t4", 11, 32'hA5A5_0040, 1, 32'h4);
      set_addr(32'h10); measure("t4_hit", 0, 32'hA5A5_0010, 0, 32'h0);

      // 5: reset two cycles into MEM_READ
      set_addr(32'h20);
      repeat (3) @(negedge clk);
      check("t5_pre_mem_read", 32'(mem_read), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("t5_mem_read", 32'(mem_read), 32'd0);
      check("t5_busywait", 32'(busywait), 32'd0);
      check("t5_mem_addr", {4'b0, mem_address}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 begin
         reset   = 1'b1;
         address = 32'h0;
      end
      measure("t5", 7, 32'hA5A5_0000, 1, 32'h0);

      // 6: memory answers immediately
      zero_mode = 1'b1;
      set_addr(32'h30); measure("t6", 3, 32'hA5A5_0030, 1, 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
